// File: rtl/int_to_float_pkg.sv
// Shared helpers and stage control payload for the integer-to-float converter.
package int_to_float_pkg;

  function automatic int unsigned bias(input int unsigned exp_width);
    return (32'd1 << (exp_width - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd32;
    for (int i = 31; i >= 0; i--) begin
      if ((33'd1 << i) >= 33'(value)) result = 32'(i);
    end
    return result;
  endfunction

  function automatic int unsigned float_width(input int unsigned exp_width,
                                              input int unsigned man_width);
    return 32'd1 + exp_width + man_width;
  endfunction

  // Per-sample flags carried alongside the magnitude through the pipeline.
  typedef struct packed {
    logic sign;
    logic zero;
    logic rtz;
  } ctl_t;

endpackage

// File: rtl/int_to_float_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module int_to_float_lzc #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned OUT_WIDTH = 6
) (
  input  logic [WIDTH-1:0]     data,
  output logic [OUT_WIDTH-1:0] count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = OUT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = OUT_WIDTH'(WIDTH - 32'd1 - 32'(i));
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Four-stage integer to IEEE-754 converter with a valid/ready stream and a
// global pipeline enable; supports RNE and RTZ rounding per sample.
module int_to_float
  import int_to_float_pkg::*;
#(
  parameter int unsigned INT_WIDTH = 32,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23,
  parameter bit          SIGNED    = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [INT_WIDTH-1:0]                       in_data,
  input  logic                                       in_rtz,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [float_width(EXP_WIDTH, MAN_WIDTH)-1:0] out_data,
  output logic                                       out_inexact,
  output logic                                       out_valid,
  input  logic                                       out_ready
);

  localparam int unsigned FLOAT_WIDTH = float_width(EXP_WIDTH, MAN_WIDTH);
  localparam int unsigned LZ_WIDTH    = clog2(INT_WIDTH + 32'd1);
  localparam int unsigned E_TOP       = bias(EXP_WIDTH) + INT_WIDTH - 32'd1;

  logic adv;
  logic v1, v2, v3;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage 1: sign/magnitude split; magnitude is unsigned so the most-negative input is exact.
  logic                 in_sign_c;
  logic [INT_WIDTH-1:0] in_mag_c;
  ctl_t                 s1_ctl;
  logic [INT_WIDTH-1:0] s1_mag;

  assign in_sign_c = SIGNED & in_data[INT_WIDTH-1];
  assign in_mag_c  = in_sign_c ? -in_data : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      s1_ctl <= '0;
      s1_mag <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_ctl <= '{sign: in_sign_c, zero: (in_mag_c == '0), rtz: in_rtz};
        s1_mag <= in_mag_c;
      end
    end
  end

  // Stage 2: leading-zero count and biased exponent.
  logic [LZ_WIDTH-1:0]  lz_c;
  ctl_t                 s2_ctl;
  logic [INT_WIDTH-1:0] s2_mag;
  logic [LZ_WIDTH-1:0]  s2_lz;
  logic [EXP_WIDTH-1:0] s2_e;

  int_to_float_lzc #(
    .WIDTH     (INT_WIDTH),
    .OUT_WIDTH (LZ_WIDTH)
  ) u_lzc (
    .data  (s1_mag),
    .count (lz_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      s2_ctl <= '0;
      s2_mag <= '0;
      s2_lz  <= '0;
      s2_e   <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        s2_ctl <= s1_ctl;
        s2_mag <= s1_mag;
        s2_lz  <= lz_c;
        s2_e   <= EXP_WIDTH'(E_TOP) - EXP_WIDTH'(lz_c);
      end
    end
  end

  // Stage 3: normalise (hidden bit dropped), extract fraction, guard and sticky.
  logic [INT_WIDTH-2:0] norm_c;
  logic [MAN_WIDTH-1:0] frac_c;
  logic                 guard_c;
  logic                 sticky_c;
  logic                 inc_c;
  logic                 inexact_c;

  assign norm_c = (INT_WIDTH-1)'(s2_mag << s2_lz);

  if (INT_WIDTH - 1 > MAN_WIDTH) begin : g_round
    localparam int unsigned DROP = INT_WIDTH - 1 - MAN_WIDTH;
    assign frac_c  = norm_c[INT_WIDTH-2 -: MAN_WIDTH];
    assign guard_c = norm_c[DROP-1];
    if (DROP > 1) begin : g_sticky
      assign sticky_c = |norm_c[DROP-2:0];
    end else begin : g_no_sticky
      assign sticky_c = 1'b0;
    end
  end else if (INT_WIDTH - 1 == MAN_WIDTH) begin : g_fit
    assign frac_c   = norm_c;
    assign guard_c  = 1'b0;
    assign sticky_c = 1'b0;
  end else begin : g_pad
    assign frac_c   = {norm_c, {(MAN_WIDTH - INT_WIDTH + 1){1'b0}}};
    assign guard_c  = 1'b0;
    assign sticky_c = 1'b0;
  end

  assign inc_c     = ~s2_ctl.rtz & guard_c & (sticky_c | frac_c[0]);
  assign inexact_c = guard_c | sticky_c;

  logic                 s3_sign;
  logic                 s3_zero;
  logic [MAN_WIDTH-1:0] s3_frac;
  logic                 s3_inc;
  logic                 s3_inexact;
  logic [EXP_WIDTH-1:0] s3_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3         <= 1'b0;
      s3_sign    <= 1'b0;
      s3_zero    <= 1'b0;
      s3_frac    <= '0;
      s3_inc     <= 1'b0;
      s3_inexact <= 1'b0;
      s3_e       <= '0;
    end else if (adv) begin
      v3 <= v2;
      if (v2) begin
        s3_sign    <= s2_ctl.sign;
        s3_zero    <= s2_ctl.zero;
        s3_frac    <= frac_c;
        s3_inc     <= inc_c;
        s3_inexact <= inexact_c;
        s3_e       <= s2_e;
      end
    end
  end

  // Stage 4: apply increment; a fraction carry bumps the exponent.
  logic [MAN_WIDTH:0]     sum_c;
  logic [EXP_WIDTH-1:0]   e_out_c;
  logic [FLOAT_WIDTH-1:0] result_c;

  assign sum_c    = {1'b0, s3_frac} + (MAN_WIDTH+1)'(s3_inc);
  assign e_out_c  = s3_e + EXP_WIDTH'(sum_c[MAN_WIDTH]);
  assign result_c = s3_zero ? '0 : {s3_sign, e_out_c, sum_c[MAN_WIDTH-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else if (adv) begin
      out_valid <= v3;
      if (v3) begin
        out_data    <= result_c;
        out_inexact <= s3_inexact & ~s3_zero;
      end
    end
  end

endmodule
